// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, oversampling constants and baud divider helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
  localparam int OVERSAMPLE = 16;
  localparam int VOTE_LO = 7;
  localparam int VOTE_HI = 9;
  function automatic int calc_div(input longint clk_hz, input longint baud);
    return int'((clk_hz + baud * OVERSAMPLE / 2) / (baud * OVERSAMPLE));
  endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: receiver line and byte-strobe bundle; master = line driver/consumer, slave = receiver
interface uart_rx_if;
  logic       RXD;
  logic [7:0] DATA;
  logic       VALID;
  logic       FRAME_ERR;
  logic       BUSY;
  modport master (output RXD, input DATA, VALID, FRAME_ERR, BUSY);
  modport slave (input RXD, output DATA, VALID, FRAME_ERR, BUSY);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: clk divider, one-cycle o_tick every DIV clocks, i_restart realigns phase to zero
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic i_restart,
  output logic o_tick
);
  localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
  logic [W-1:0] r_cnt;
  assign o_tick = r_cnt == W'(DIV - 1);
  always_ff @(posedge clk) begin
    if (rst || i_restart) r_cnt <= '0;
    else r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver, 16x oversampling, 3-sample majority vote; ports CLK_50MHZ, RST, bus (RXD in; DATA, VALID, FRAME_ERR, BUSY out)
module uart_rx import uart_pkg::*; #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input logic      CLK_50MHZ,
  input logic      RST,
  uart_rx_if.slave bus
);
  localparam int DIV = calc_div(CLK_HZ, BAUD);
  if (OVERSAMPLE != 16) begin : g_os_check
    $error("uart_rx: OVERSAMPLE must be 16");
  end
  state_t     r_state, w_next;
  logic [1:0] r_sync;
  logic       r_prev;
  logic [3:0] r_scnt;
  logic [2:0] r_idx;
  logic [7:0] r_shreg, r_data;
  logic [1:0] r_smp;
  logic       r_valid, r_ferr;
  logic       w_rxs, w_tick, w_fall, w_start, w_decide, w_wrap, w_vote, w_valid, w_ferr;
  assign w_rxs    = r_sync[1];
  assign w_fall   = r_prev & ~w_rxs;
  assign w_start  = (r_state == IDLE) & w_fall;
  // samples land as scnt steps onto 7, 8 and 9; the third is taken live at the decision
  assign w_decide = w_tick & (r_scnt == 4'(VOTE_HI - 1));
  assign w_wrap   = w_tick & (r_scnt == 4'd15);
  assign w_vote   = (r_smp[0] & r_smp[1]) | (r_smp[0] & w_rxs) | (r_smp[1] & w_rxs);
  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk      (CLK_50MHZ),
    .rst      (RST),
    .i_restart(w_start),
    .o_tick   (w_tick)
  );
  always_ff @(posedge CLK_50MHZ) begin
    if (RST) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = w_fall ? START : IDLE;
      START:     w_next = (w_decide && w_vote) ? IDLE : w_wrap ? DATA : START;
      DATA:      w_next = (w_wrap && r_idx == 3'd7) ? STOP : DATA;
      STOP:      w_next = w_decide ? (w_vote ? IDLE : WAIT_IDLE) : STOP;
      WAIT_IDLE: w_next = w_rxs ? IDLE : WAIT_IDLE;
      default:   w_next = IDLE;
    endcase
  end
  always_comb begin
    w_valid  = (r_state == STOP) & w_decide & w_vote;
    w_ferr   = (r_state == STOP) & w_decide & ~w_vote;
    bus.BUSY = r_state != IDLE;
  end
  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      r_sync  <= 2'b11;
      r_prev  <= 1'b1;
      r_scnt  <= '0;
      r_idx   <= '0;
      r_smp   <= '0;
      r_shreg <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], bus.RXD};
      r_prev  <= w_rxs;
      r_valid <= w_valid;
      r_ferr  <= w_ferr;
      if (w_valid) r_data <= r_shreg;
      if (w_start) r_scnt <= '0;
      else if (w_tick) r_scnt <= r_scnt + 1'b1;
      if (w_tick && r_scnt == 4'(VOTE_LO - 1)) r_smp[0] <= w_rxs;
      if (w_tick && r_scnt == 4'(VOTE_LO)) r_smp[1] <= w_rxs;
      if (r_state == START) r_idx <= '0;
      else if (r_state == DATA && w_wrap) r_idx <= r_idx + 1'b1;
      if (r_state == DATA && w_decide) r_shreg[r_idx] <= w_vote;
    end
  end
  assign bus.DATA      = r_data;
  assign bus.VALID     = r_valid;
  assign bus.FRAME_ERR = r_ferr;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized 8N1 frames checked against a queue of expected bytes
module tb_uart_rx;
  logic clk, rst;
  int checks, errors, cyc;
  int valid_cnt, ferr_cnt, both_cnt, busy_cnt, last_vcyc, busy_fall;
  logic busy_prev;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  uart_rx_if bus();
  uart_rx dut (.CLK_50MHZ(clk), .RST(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    cyc = 0; valid_cnt = 0; ferr_cnt = 0; both_cnt = 0; busy_cnt = 0;
    last_vcyc = 0; busy_fall = 0; busy_prev = 1'b0;
  end
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.VALID) begin
      valid_cnt++;
      last_vcyc = cyc;
      rx_q.push_back(bus.DATA);
    end
    if (bus.FRAME_ERR) ferr_cnt++;
    if (bus.VALID && bus.FRAME_ERR) both_cnt++;
    if (bus.BUSY) busy_cnt++;
    if (busy_prev && !bus.BUSY) busy_fall = cyc;
    busy_prev = bus.BUSY;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b, input int bp);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.RXD = f[i];
      cyc_n(bp);
    end
  endtask
  initial begin
    int t0, vc, fc, bp;
    logic [9:0] f;
    logic [7:0] b;
    checks = 0; errors = 0;
    rst = 1'b1; bus.RXD = 1'b1;
    @(posedge clk); #1;
    cyc_n(4);
    check("rst_data", bus.DATA, 8'h00);
    check("rst_valid", bus.VALID, 1'b0);
    check("rst_ferr", bus.FRAME_ERR, 1'b0);
    check("rst_busy", bus.BUSY, 1'b0);
    rst = 1'b0;
    cyc_n(10000);
    check("idle_valid", valid_cnt, 0);
    check("idle_ferr", ferr_cnt, 0);
    check("idle_busy", busy_cnt, 0);
    check("idle_data", bus.DATA, 8'h00);
    t0 = cyc;
    send(8'hA5, 432);
    exp_q.push_back(8'hA5);
    cyc_n(500);
    check("a5_count", valid_cnt, 1);
    check("a5_data", bus.DATA, 8'hA5);
    check("a5_ferr", ferr_cnt, 0);
    check("a5_latency", (last_vcyc - t0 >= 4107 - 27) && (last_vcyc - t0 <= 4107 + 27), 1'b1);
    send(8'h00, 432); exp_q.push_back(8'h00);
    send(8'hFF, 432); exp_q.push_back(8'hFF);
    send(8'h55, 432); exp_q.push_back(8'h55);
    cyc_n(300);
    check("b2b_count", valid_cnt, 4);
    check("b2b_ferr", ferr_cnt, 0);
    check("b2b_data", bus.DATA, 8'h55);
    t0 = cyc;
    bus.RXD = 1'b0;
    cyc_n(100);
    bus.RXD = 1'b1;
    cyc_n(600);
    check("glitch_busy_drop", (busy_fall - t0 >= 243 - 27) && (busy_fall - t0 <= 243 + 27), 1'b1);
    check("glitch_valid", valid_cnt, 4);
    check("glitch_ferr", ferr_cnt, 0);
    bus.RXD = 1'b0;
    cyc_n(12 * 432);
    check("break_ferr", ferr_cnt, 1);
    check("break_valid", valid_cnt, 4);
    check("break_data", bus.DATA, 8'h55);
    check("break_busy_hold", bus.BUSY, 1'b1);
    bus.RXD = 1'b1;
    cyc_n(10);
    check("break_busy_release", bus.BUSY, 1'b0);
    send(8'h3C, 432); exp_q.push_back(8'h3C);
    cyc_n(200);
    check("after_break_data", bus.DATA, 8'h3C);
    check("after_break_ferr", ferr_cnt, 1);
    f = {1'b1, 8'hC3, 1'b0};
    for (int i = 0; i < 5; i++) begin
      bus.RXD = f[i];
      cyc_n(432);
    end
    bus.RXD = f[5];
    cyc_n(216);
    check("c3_busy_before_rst", bus.BUSY, 1'b1);
    vc = valid_cnt; fc = ferr_cnt;
    rst = 1'b1;
    cyc_n(1);
    check("c3_busy_after_rst", bus.BUSY, 1'b0);
    cyc_n(215);
    for (int i = 6; i < 10; i++) begin
      bus.RXD = f[i];
      cyc_n(432);
    end
    cyc_n(100);
    rst = 1'b0;
    cyc_n(50);
    check("c3_no_valid", valid_cnt, vc);
    check("c3_no_ferr", ferr_cnt, fc);
    send(8'h81, 432); exp_q.push_back(8'h81);
    cyc_n(200);
    check("after_rst_data", bus.DATA, 8'h81);
    send(8'h96, 419); exp_q.push_back(8'h96);
    cyc_n(200);
    check("slow_skew_data", bus.DATA, 8'h96);
    send(8'h69, 432); exp_q.push_back(8'h69);
    cyc_n(100);
    send(8'h96, 445); exp_q.push_back(8'h96);
    cyc_n(200);
    check("fast_skew_data", bus.DATA, 8'h96);
    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom);
      bp = int'($urandom_range(419, 445));
      send(b, bp);
      exp_q.push_back(b);
      cyc_n(int'($urandom_range(1, 300)));
      check("rand_data", bus.DATA, b);
    end
    check("total_count", rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) check("stream_byte", rx_q[i], exp_q[i]);
    check("total_ferr", ferr_cnt, 1);
    check("valid_ferr_overlap", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
